// File: rtl/sal_bank_ctrl.sv
// Per-bank controller: holds one decoded request, tracks the bank state and
// requests ACT/RD/WR/PRE/REF from the inter-bank scheduler under intra-bank timing.
module sal_bank_ctrl #(
  parameter int unsigned RA_W   = 16,
  parameter int unsigned CA_W   = 10,
  parameter int unsigned ID_W   = 4,
  parameter int unsigned LEN_W  = 4,
  parameter int unsigned SEQ_W  = 8,
  parameter int unsigned CNTR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_wr_i,
  input  logic [RA_W-1:0]   req_ra_i,
  input  logic [CA_W-1:0]   req_ca_i,
  input  logic [ID_W-1:0]   req_id_i,
  input  logic [LEN_W-1:0]  req_len_i,
  input  logic [SEQ_W-1:0]  req_seq_i,
  input  logic              ref_req_i,
  output logic              ref_done_o,
  input  logic [CNTR_W-1:0] t_rcd_m1,
  input  logic [CNTR_W-1:0] t_ras_m1,
  input  logic [CNTR_W-1:0] t_rtp_m1,
  input  logic [CNTR_W-1:0] t_wtp_m1,
  input  logic [CNTR_W-1:0] t_rp_m1,
  input  logic [CNTR_W-1:0] t_rfc_m1,
  output logic              act_req_o,
  output logic              rd_req_o,
  output logic              wr_req_o,
  output logic              pre_req_o,
  output logic              ref_req_o,
  input  logic              act_gnt_i,
  input  logic              rd_gnt_i,
  input  logic              wr_gnt_i,
  input  logic              pre_gnt_i,
  input  logic              ref_gnt_i,
  output logic [RA_W-1:0]   ra_o,
  output logic [CA_W-1:0]   ca_o,
  output logic [ID_W-1:0]   id_o,
  output logic [LEN_W-1:0]  len_o,
  output logic [SEQ_W-1:0]  seq_num_o
);

  localparam logic [2:0] ST_CLOSED      = 3'd0;
  localparam logic [2:0] ST_ACTIVATING  = 3'd1;
  localparam logic [2:0] ST_OPEN        = 3'd2;
  localparam logic [2:0] ST_PRECHARGING = 3'd3;
  localparam logic [2:0] ST_REFRESHING  = 3'd4;

  localparam logic [2:0] CMD_NONE = 3'd0;
  localparam logic [2:0] CMD_ACT  = 3'd1;
  localparam logic [2:0] CMD_RD   = 3'd2;
  localparam logic [2:0] CMD_WR   = 3'd3;
  localparam logic [2:0] CMD_PRE  = 3'd4;
  localparam logic [2:0] CMD_REF  = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [2:0]        hold_q, hold_d;
  logic              vld_q, vld_d;
  logic              wr_q, wr_d;
  logic [RA_W-1:0]   ra_q, ra_d;
  logic [CA_W-1:0]   ca_q, ca_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [SEQ_W-1:0]  seq_q, seq_d;
  logic              ref_pend_q, ref_pend_d;
  logic [RA_W-1:0]   open_row_q, open_row_d;
  logic [CNTR_W-1:0] rcd_q, rcd_d, ras_q, ras_d, rtp_q, rtp_d;
  logic [CNTR_W-1:0] wtp_q, wtp_d, rp_q, rp_d, rfc_q, rfc_d;

  logic [2:0] cmd_c;
  logic       act_g, rd_g, wr_g, pre_g, ref_g, any_g, cap;

  function automatic logic [CNTR_W-1:0] cnt_dec(input logic [CNTR_W-1:0] c);
    return (c == '0) ? '0 : c - CNTR_W'(1);
  endfunction

  // Command select: a request left ungranted is re-issued unchanged
  always_comb begin
    cmd_c = CMD_NONE;
    if (hold_q != CMD_NONE) begin
      cmd_c = hold_q;
    end else begin
      case (state_q)
        ST_CLOSED: begin
          if (ref_pend_q)  cmd_c = CMD_REF;
          else if (vld_q)  cmd_c = CMD_ACT;
        end
        ST_OPEN: begin
          if (ref_pend_q || (vld_q && (ra_q != open_row_q))) begin
            if ((ras_q == '0) && (rtp_q == '0) && (wtp_q == '0)) cmd_c = CMD_PRE;
          end else if (vld_q) begin
            cmd_c = wr_q ? CMD_WR : CMD_RD;
          end
        end
        default: cmd_c = CMD_NONE;
      endcase
    end
  end

  assign act_req_o = (cmd_c == CMD_ACT);
  assign rd_req_o  = (cmd_c == CMD_RD);
  assign wr_req_o  = (cmd_c == CMD_WR);
  assign pre_req_o = (cmd_c == CMD_PRE);
  assign ref_req_o = (cmd_c == CMD_REF);

  // Grants only count against the command actually being requested
  assign act_g = act_gnt_i & act_req_o;
  assign rd_g  = rd_gnt_i  & rd_req_o;
  assign wr_g  = wr_gnt_i  & wr_req_o;
  assign pre_g = pre_gnt_i & pre_req_o;
  assign ref_g = ref_gnt_i & ref_req_o;
  assign any_g = act_g | rd_g | wr_g | pre_g | ref_g;

  always_comb begin
    state_d    = state_q;
    hold_d     = CMD_NONE;
    vld_d      = vld_q;
    wr_d       = wr_q;
    ra_d       = ra_q;
    ca_d       = ca_q;
    id_d       = id_q;
    len_d      = len_q;
    seq_d      = seq_q;
    open_row_d = open_row_q;
    cap        = req_valid_i & ~vld_q;

    rcd_d = act_g ? t_rcd_m1 : cnt_dec(rcd_q);
    ras_d = act_g ? t_ras_m1 : cnt_dec(ras_q);
    rtp_d = rd_g  ? t_rtp_m1 : cnt_dec(rtp_q);
    wtp_d = wr_g  ? t_wtp_m1 : cnt_dec(wtp_q);
    rp_d  = pre_g ? t_rp_m1  : cnt_dec(rp_q);
    rfc_d = ref_g ? t_rfc_m1 : cnt_dec(rfc_q);

    ref_pend_d = (ref_pend_q & ~ref_g) | ref_req_i;

    if ((cmd_c != CMD_NONE) && !any_g) hold_d = cmd_c;

    if (rd_g || wr_g) begin
      vld_d = 1'b0;
    end else if (cap) begin
      vld_d = 1'b1;
      wr_d  = req_wr_i;
      ra_d  = req_ra_i;
      ca_d  = req_ca_i;
      id_d  = req_id_i;
      len_d = req_len_i;
      seq_d = req_seq_i;
    end

    if (act_g) open_row_d = ra_q;

    // Wait states end on the edge where the counter reaches zero, so the
    // dependent request shows up exactly t cycles after its grant
    case (state_q)
      ST_CLOSED: begin
        if (act_g)      state_d = (rcd_d == '0) ? ST_OPEN : ST_ACTIVATING;
        else if (ref_g) state_d = ST_REFRESHING;
      end
      ST_ACTIVATING:  if (rcd_d == '0) state_d = ST_OPEN;
      ST_OPEN:        if (pre_g) state_d = (rp_d == '0) ? ST_CLOSED : ST_PRECHARGING;
      ST_PRECHARGING: if (rp_d == '0) state_d = ST_CLOSED;
      ST_REFRESHING:  if (rfc_q == '0) state_d = ST_CLOSED;
      default:        state_d = ST_CLOSED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_CLOSED;
      hold_q     <= CMD_NONE;
      vld_q      <= 1'b0;
      wr_q       <= 1'b0;
      ra_q       <= '0;
      ca_q       <= '0;
      id_q       <= '0;
      len_q      <= '0;
      seq_q      <= '0;
      ref_pend_q <= 1'b0;
      open_row_q <= '0;
      rcd_q      <= '0;
      ras_q      <= '0;
      rtp_q      <= '0;
      wtp_q      <= '0;
      rp_q       <= '0;
      rfc_q      <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      vld_q      <= vld_d;
      wr_q       <= wr_d;
      ra_q       <= ra_d;
      ca_q       <= ca_d;
      id_q       <= id_d;
      len_q      <= len_d;
      seq_q      <= seq_d;
      ref_pend_q <= ref_pend_d;
      open_row_q <= open_row_d;
      rcd_q      <= rcd_d;
      ras_q      <= ras_d;
      rtp_q      <= rtp_d;
      wtp_q      <= wtp_d;
      rp_q       <= rp_d;
      rfc_q      <= rfc_d;
    end
  end

  assign req_ready_o = ~vld_q;
  assign ref_done_o  = (state_q == ST_REFRESHING) && (rfc_q == '0);
  assign ra_o        = ra_q;
  assign ca_o        = ca_q;
  assign id_o        = id_q;
  assign len_o       = len_q;
  assign seq_num_o   = seq_q;

`ifndef SYNTHESIS
  // Scheduler protocol checks
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert ($onehot0({act_gnt_i, rd_gnt_i, wr_gnt_i, pre_gnt_i, ref_gnt_i}))
        else $error("sal_bank_ctrl: multiple grants in one cycle");
      assert (({act_gnt_i, rd_gnt_i, wr_gnt_i, pre_gnt_i, ref_gnt_i} &
               ~{act_req_o, rd_req_o, wr_req_o, pre_req_o, ref_req_o}) == 5'd0)
        else $error("sal_bank_ctrl: grant without matching request");
    end
  end
`endif

endmodule

// File: tb/tb_sal_bank_ctrl.sv
// Bench for sal_bank_ctrl: directed scheduler scenarios plus randomized traffic,
// checked every cycle against a timestamp-based model of the bank.
module tb_sal_bank_ctrl;
  localparam int unsigned RA_W = 16, CA_W = 10, ID_W = 4, LEN_W = 4, SEQ_W = 8, CNTR_W = 6;
  localparam int K_ACT = 0, K_RD = 1, K_WR = 2, K_PRE = 3, K_REF = 4;
  localparam int PH_CLOSED = 0, PH_ACTG = 1, PH_OPEN = 2, PH_PREG = 3, PH_REFG = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic req_valid_i, req_ready_o, req_wr_i, ref_req_i, ref_done_o;
  logic [RA_W-1:0] req_ra_i, ra_o;
  logic [CA_W-1:0] req_ca_i, ca_o;
  logic [ID_W-1:0] req_id_i, id_o;
  logic [LEN_W-1:0] req_len_i, len_o;
  logic [SEQ_W-1:0] req_seq_i, seq_num_o;
  logic [CNTR_W-1:0] t_rcd_m1, t_ras_m1, t_rtp_m1, t_wtp_m1, t_rp_m1, t_rfc_m1;
  logic act_req_o, rd_req_o, wr_req_o, pre_req_o, ref_req_o;
  logic act_gnt_i, rd_gnt_i, wr_gnt_i, pre_gnt_i, ref_gnt_i;

  always #5 clk = ~clk;

  sal_bank_ctrl #(.RA_W(RA_W), .CA_W(CA_W), .ID_W(ID_W), .LEN_W(LEN_W),
                  .SEQ_W(SEQ_W), .CNTR_W(CNTR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_wr_i(req_wr_i),
    .req_ra_i(req_ra_i), .req_ca_i(req_ca_i), .req_id_i(req_id_i),
    .req_len_i(req_len_i), .req_seq_i(req_seq_i),
    .ref_req_i(ref_req_i), .ref_done_o(ref_done_o),
    .t_rcd_m1(t_rcd_m1), .t_ras_m1(t_ras_m1), .t_rtp_m1(t_rtp_m1),
    .t_wtp_m1(t_wtp_m1), .t_rp_m1(t_rp_m1), .t_rfc_m1(t_rfc_m1),
    .act_req_o(act_req_o), .rd_req_o(rd_req_o), .wr_req_o(wr_req_o),
    .pre_req_o(pre_req_o), .ref_req_o(ref_req_o),
    .act_gnt_i(act_gnt_i), .rd_gnt_i(rd_gnt_i), .wr_gnt_i(wr_gnt_i),
    .pre_gnt_i(pre_gnt_i), .ref_gnt_i(ref_gnt_i),
    .ra_o(ra_o), .ca_o(ca_o), .id_o(id_o), .len_o(len_o), .seq_num_o(seq_num_o)
  );

  int n, n_chk, n_bad;
  // Reference model: bank phase is derived from the last grant and its cycle stamp
  bit m_held, m_wr, m_refp;
  logic [RA_W-1:0] m_ra, m_open_row;
  logic [CA_W-1:0] m_ca;
  logic [ID_W-1:0] m_id;
  logic [LEN_W-1:0] m_len;
  logic [SEQ_W-1:0] m_seq;
  int m_last, m_cur;
  int t_act, t_rd, t_wr, t_pre, t_ref;
  int rcd, ras, rtp, wtp, rp, rfc;
  int first_req[5], gnt_at[5];
  int done_at, ref_gnts;
  logic [4:0] prev_bits;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, n);
    end
  endtask

  task automatic model_reset();
    m_held = 0; m_wr = 0; m_refp = 0;
    m_ra = '0; m_ca = '0; m_id = '0; m_len = '0; m_seq = '0; m_open_row = '0;
    m_last = -1; m_cur = -1;
    t_act = -1000; t_rd = -1000; t_wr = -1000; t_pre = -1000; t_ref = -1000;
    rcd = int'(t_rcd_m1) + 1; ras = int'(t_ras_m1) + 1; rtp = int'(t_rtp_m1) + 1;
    wtp = int'(t_wtp_m1) + 1; rp = int'(t_rp_m1) + 1; rfc = int'(t_rfc_m1) + 1;
    prev_bits = '0;
  endtask

  function automatic int phase_now();
    case (m_last)
      K_ACT:       return (n < t_act + rcd) ? PH_ACTG : PH_OPEN;
      K_RD, K_WR:  return PH_OPEN;
      K_PRE:       return (n < t_pre + rp) ? PH_PREG : PH_CLOSED;
      K_REF:       return (n <= t_ref + rfc) ? PH_REFG : PH_CLOSED;
      default:     return PH_CLOSED;
    endcase
  endfunction

  function automatic int exp_cmd();
    int ph;
    if (m_cur >= 0) return m_cur;
    ph = phase_now();
    if (ph == PH_CLOSED) return m_refp ? K_REF : (m_held ? K_ACT : -1);
    if (ph == PH_OPEN) begin
      if (m_refp || (m_held && m_ra != m_open_row))
        return (n >= t_act + ras && n >= t_rd + rtp && n >= t_wr + wtp) ? K_PRE : -1;
      return m_held ? (m_wr ? K_WR : K_RD) : -1;
    end
    return -1;
  endfunction

  function automatic logic [RA_W-1:0] pick_ra();
    case ($urandom_range(2))
      0:       return 16'h0012;
      1:       return 16'h0034;
      default: return RA_W'($urandom);
    endcase
  endfunction

  // One clock: check outputs, drive inputs, advance the model across the edge
  task automatic cycle(input bit rst_v, input bit v, input bit w, input logic [RA_W-1:0] ra,
                       input int gpct, input bit rf, input bit junk);
    int e, gk;
    bit cap;
    logic [4:0] bits, ebits, g;
    logic [CA_W-1:0] ca;
    logic [ID_W-1:0] id;
    logic [LEN_W-1:0] len;
    logic [SEQ_W-1:0] seq;
    e = exp_cmd();
    bits = {ref_req_o, pre_req_o, wr_req_o, rd_req_o, act_req_o};
    ebits = 5'd0;
    if (e >= 0) ebits[e] = 1'b1;
    check_eq("cmd", bits, ebits);
    check_eq("ready", req_ready_o, !m_held);
    check_eq("ref_done", ref_done_o, (phase_now() == PH_REFG) && (n == t_ref + rfc));
    check_eq("ra", ra_o, m_ra);
    check_eq("ca", ca_o, m_ca);
    check_eq("id", id_o, m_id);
    check_eq("len", len_o, m_len);
    check_eq("seq", seq_num_o, m_seq);
    for (int k = 0; k < 5; k++) if (bits[k] && !prev_bits[k]) first_req[k] = n;
    prev_bits = bits;
    if (ref_done_o === 1'b1) done_at = n;
    g = 5'd0; gk = -1;
    if (junk) g = 5'($urandom);
    else if (e >= 0 && int'($urandom_range(99)) < gpct) begin g[e] = 1'b1; gk = e; end
    if (gk >= 0) begin gnt_at[gk] = n; if (gk == K_REF) ref_gnts++; end
    ca = CA_W'($urandom); id = ID_W'($urandom); len = LEN_W'($urandom); seq = SEQ_W'($urandom);
    rst_n = rst_v; req_valid_i = v; req_wr_i = w; req_ra_i = ra;
    req_ca_i = ca; req_id_i = id; req_len_i = len; req_seq_i = seq; ref_req_i = rf;
    {ref_gnt_i, pre_gnt_i, wr_gnt_i, rd_gnt_i, act_gnt_i} = g;
    @(posedge clk);
    if (!rst_v) begin
      model_reset();
    end else begin
      cap = v && !m_held;
      case (gk)
        K_ACT: begin t_act = n; m_open_row = m_ra; end
        K_RD:  t_rd = n;
        K_WR:  t_wr = n;
        K_PRE: t_pre = n;
        K_REF: t_ref = n;
        default: ;
      endcase
      m_cur = (e >= 0 && gk < 0) ? e : -1;
      if (gk == K_RD || gk == K_WR) m_held = 0;
      if (cap) begin
        m_held = 1; m_wr = w; m_ra = ra; m_ca = ca; m_id = id; m_len = len; m_seq = seq;
      end
      m_refp = (m_refp && gk != K_REF) || rf;
      if (gk >= 0) m_last = gk;
    end
    n++;
    @(negedge clk);
  endtask

  task automatic idle(input int k, input int gpct);
    repeat (k) cycle(1, 0, 0, '0, gpct, 0, 0);
  endtask

  task automatic send(input bit w, input logic [RA_W-1:0] ra, input int gpct);
    int k;
    k = 0;
    while (m_held && k < 300) begin cycle(1, 0, 0, '0, gpct, 0, 0); k++; end
    cycle(1, 1, w, ra, gpct, 0, 0);
  endtask

  task automatic set_params(input int a, input int b, input int c, input int d,
                            input int e, input int f);
    t_rcd_m1 = CNTR_W'(a); t_ras_m1 = CNTR_W'(b); t_rtp_m1 = CNTR_W'(c);
    t_wtp_m1 = CNTR_W'(d); t_rp_m1 = CNTR_W'(e); t_rfc_m1 = CNTR_W'(f);
  endtask

  task automatic do_reset(input int k);
    repeat (k) cycle(0, 0, 0, '0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin first_req[i] = -1; gnt_at[i] = -1; end
    done_at = -1; ref_gnts = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired cycle=%0d", n);
    $fatal(1, "watchdog");
  end

  initial begin
    int a_act, pre_before, gp;
    n = 0; n_chk = 0; n_bad = 0;
    rst_n = 0; req_valid_i = 0; req_wr_i = 0; req_ra_i = '0; req_ca_i = '0;
    req_id_i = '0; req_len_i = '0; req_seq_i = '0; ref_req_i = 0;
    {ref_gnt_i, pre_gnt_i, wr_gnt_i, rd_gnt_i, act_gnt_i} = '0;
    set_params(3, 9, 1, 5, 2, 7);
    @(posedge clk); @(negedge clk);
    model_reset();

    // Reset held with a valid request and toggling grants
    for (int i = 0; i < 5; i++) cycle(0, 1, 1'(i), 16'h0012, 0, 1'(i), 1);
    do_reset(1);
    idle(3, 100);

    // Read to closed bank
    send(0, 16'h0012, 100);
    idle(8, 100);
    check_eq("rcd_gap", 64'(first_req[K_RD] - gnt_at[K_ACT]), 64'd4);

    // Row-hit write then read, then row miss
    send(1, 16'h0012, 100);
    idle(3, 100);
    send(0, 16'h0012, 100);
    idle(3, 100);
    pre_before = gnt_at[K_PRE];
    check_eq("hit_no_pre", 64'(pre_before), 64'(-1));
    a_act = gnt_at[K_ACT];
    send(0, 16'h0034, 100);
    idle(25, 100);
    check_eq("wtp_to_pre", 64'(first_req[K_PRE] - gnt_at[K_WR] >= 6), 64'd1);
    check_eq("ras_to_pre", 64'(first_req[K_PRE] - a_act >= 10), 64'd1);
    check_eq("rp_to_act", 64'(first_req[K_ACT] - gnt_at[K_PRE]), 64'd3);

    // Stalled read with refresh pulses arriving, then refresh flow
    send(0, 16'h0034, 0);
    ref_gnts = 0;
    for (int i = 0; i < 20; i++) cycle(1, 0, 0, '0, 0, (i == 2 || i == 6 || i == 11), 0);
    idle(40, 100);
    check_eq("ref_merge", 64'(ref_gnts), 64'd1);
    check_eq("rfc_gap", 64'(done_at - gnt_at[K_REF]), 64'd8);
    send(0, 16'h0034, 100);
    idle(10, 100);
    check_eq("reopen_after_ref", 64'(gnt_at[K_ACT] > done_at), 64'd1);

    // Randomized traffic with varying timing and scheduler backpressure
    for (int p = 0; p < 4; p++) begin
      set_params($urandom_range(7), $urandom_range(7), $urandom_range(7),
                 $urandom_range(7), $urandom_range(7), $urandom_range(7));
      if (p == 0) set_params(0, 0, 0, 0, 0, 0);
      do_reset(2);
      gp = (p == 0) ? 100 : (p == 1) ? 60 : (p == 2) ? 25 : 5;
      for (int i = 0; i < 1500; i++) begin
        if (p == 2 && i == 700)
          cycle(0, 1, 1, pick_ra(), 0, 1, 1);
        else
          cycle(1, int'($urandom_range(99)) < 40, 1'($urandom_range(1)), pick_ra(), gp,
                int'($urandom_range(99)) < 3, 0);
      end
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/sal_bank_ctrl.md
Name: sal_bank_ctrl

Overview:
Per-bank controller: the requesting side of the bank-controller-to-scheduler handshake. Holds one decoded memory request and tracks the bank state (closed, activating, open row, precharging, refreshing). Issues one of ACT/RD/WR/PRE/REF requests toward the inter-bank scheduler and enforces the intra-bank timing constraints (tRCD, tRAS, tRTP, tWTP, tRP, tRFC). One instance per bank.

Parameters:
RA_W, 16, row address width
CA_W, 10, column address width
ID_W, 4, transaction id width
LEN_W, 4, burst length field width
SEQ_W, 8, global sequence number width
CNTR_W, 6, timing counter width (all t_*_m1 inputs)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
req_valid_i  in  1  decoded request valid
req_ready_o  out  1  request register empty, can accept
req_wr_i  in  1  1=write, 0=read
req_ra_i / req_ca_i / req_id_i / req_len_i / req_seq_i  in  RA_W/CA_W/ID_W/LEN_W/SEQ_W  request fields
ref_req_i  in  1  refresh-needed pulse from refresh timer
ref_done_o  out  1  1-cycle pulse when tRFC expires
t_rcd_m1, t_ras_m1, t_rtp_m1, t_wtp_m1, t_rp_m1, t_rfc_m1  in  CNTR_W each  timing minus one, static after reset
act_req_o, rd_req_o, wr_req_o, pre_req_o, ref_req_o  out  1  command requests to scheduler
act_gnt_i, rd_gnt_i, wr_gnt_i, pre_gnt_i, ref_gnt_i  in  1  grants from scheduler
ra_o  out  RA_W  row for ACT
ca_o / id_o / len_o / seq_num_o  out  CA_W/ID_W/LEN_W/SEQ_W  column command fields of held request

Behaviour:
- States: CLOSED, ACTIVATING, OPEN, PRECHARGING, REFRESHING. Reset -> CLOSED, request register empty, ref_pending=0, all counters 0, open_row=0.
- Reset outputs: req_ready_o=1, all *_req_o=0, ref_done_o=0; field outputs 0.
- Request register: captures on req_valid_i & req_ready_o; req_ready_o = register empty (registered, no combinational path from valid). Freed on the cycle rd_gnt_i/wr_gnt_i is sampled; req_ready_o=1 next cycle.
- ref_req_i sets ref_pending (sticky; repeated pulses while pending merge). Cleared on ref_gnt_i.
- Timing counter: on event edge load value_m1, else decrement saturating at 0; "met" = counter==0. Result: next dependent command requested no earlier than t cycles after the grant cycle (t = m1+1).
  tRCD, tRAS loaded on act_gnt; tRTP on rd_gnt; tWTP on wr_gnt; tRP on pre_gnt; tRFC on ref_gnt.
- Command requests, combinational from registered state, at most one asserted per cycle:
  CLOSED: ref_pending -> ref_req_o; else held request -> act_req_o with ra_o=req ra.
  ACTIVATING: no request; -> OPEN when tRCD met.
  OPEN: ref_pending, or held request with ra != open_row -> pre_req_o when tRAS, tRTP, tWTP all met. Else held row hit -> rd_req_o/wr_req_o per req_wr (tRCD already met in OPEN).
  PRECHARGING: no request; -> CLOSED when tRP met.
  REFRESHING: no request; tRFC met -> CLOSED, ref_done_o pulses that cycle.
- Grant transitions (sampled at edge): act_gnt -> ACTIVATING, open_row<=ra; pre_gnt -> PRECHARGING; ref_gnt -> REFRESHING; rd/wr_gnt stay OPEN.
- Refresh priority: once ref_pending, no further RD/WR/ACT issued; held request waits and resumes after refresh (re-activates).
- A request, once asserted, stays asserted with stable fields until granted (scheduler may stall indefinitely); exception: none — ref_pending arriving while rd/wr_req_o asserted does NOT retract it; preemption takes effect after that grant.
- Grant without matching asserted request: ignored, flagged by simulation assertion. Multiple grants in one cycle: assertion error.
- tRCD/tRAS in 0 cycles (m1=0) legal: minimum 1-cycle spacing.
- Reset mid-operation: all state abandoned, outputs return to reset values next cycle.

Test Plan:
- Reset with req_valid_i=1 and grants toggling -> req_ready_o=1, all *_req_o=0, state CLOSED after reset release.
- Read to closed bank, ra=0x12, t_rcd_m1=3, grants same cycle as request -> ACT at cycle c, rd_req_o first asserted c+4, ca/id/len/seq match request; req_ready_o=1 at c+5.
- Row hit write then read same row, t_wtp_m1=5 -> WR, RD issued without PRE; next row-miss PRE requested no earlier than WR grant +6 and ACT grant +t_ras.
- Row miss ra 0x12->0x34, t_rp_m1=2 -> pre_req_o, after pre_gnt act_req_o reasserts 3 cycles later with ra_o=0x34.
- ref_req_i pulse while OPEN with hit pending, t_rfc_m1=7 -> pending RD granted, then PRE, REF, ref_done_o pulse 8 cycles after ref_gnt, then ACT re-opens row.
- Scheduler withholds rd_gnt_i 20 cycles -> rd_req_o and all fields stable throughout, req_ready_o=0, ref_req_i pulses merge into one REF.
